bb_mem_responder: RTL and testbench
===================================

# bb_mem_responder

Memory-side responder for the black_bean core's memory port: it sits on the far end of the `mem_r_*` / `mem_w_*` buses driven by `mem_controller`. It services word reads and writes against an internal word-addressed array. Reads return data after a fixed, parameterised latency with a valid strobe, and out-of-range accesses are flagged. It is used as the on-chip data/instruction store in simulation and FPGA builds.

## Interface
- `DATA_WIDTH`, 16, word width; also the width of both address buses.
- `ADDR_BITS`, 8, implemented address bits; depth = 2^ADDR_BITS words.
- `RD_LATENCY`, 2, read latency in cycles; legal range 1..4.

- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `mem_r_en`  in  1  read request, sampled each rising edge.
- `mem_r_addr`  in  DATA_WIDTH  read word address.
- `mem_r_data`  out  DATA_WIDTH  read return data, registered.
- `mem_r_valid`  out  1  one-cycle strobe; `mem_r_data` is valid this cycle.
- `mem_w_en`  in  1  write request, sampled each rising edge.
- `mem_w_addr`  in  DATA_WIDTH  write word address.
- `mem_w_data`  in  DATA_WIDTH  write data.
- `err`  out  1  sticky out-of-range flag.
- `err_addr`  out  DATA_WIDTH  address of the first out-of-range access since reset.

## Operation
- **Clock and reset:** one clock; reset is asynchronous and active-high.
- **Reset values:**
  - `mem_r_data` = 0, `mem_r_valid` = 0, `err` = 0, `err_addr` = 0.
  - Read pipeline is flushed and all in-flight reads are discarded.
  - Array contents are not reset; they are undefined until written.
- **In-range test:** an address is in range iff bits [DATA_WIDTH-1:ADDR_BITS] are all zero.
- **Write:** when `mem_w_en`=1 and the address is in range, the array word is updated at that edge.
  - An out-of-range write is dropped.
- **Read:**
  - When `mem_r_en`=1 at edge k, the array is read at edge k and the result enters the latency pipeline.
  - An out-of-range read returns 0 and still produces a valid strobe.
- **Same-edge read and write, same in-range address:** write-first. The read returns the new `mem_w_data`.
- Writes at edges after k never alter a read already accepted at edge k.
- **Pipelining:** fully pipelined, one read accepted per cycle, no backpressure and no stall. A read and a write can be accepted on the same edge.
- **Pipeline implementation:** RD_LATENCY-stage shift of {valid, data}. The stage count is fixed at elaboration. A `RD_LATENCY` outside 1..4 is an elaboration error.
- **`mem_r_data` between strobes:** holds the last returned value while `mem_r_valid`=0.
- **Error capture:**
  - On any out-of-range read or write with `err`=0, set `err`=1 and capture the offending address into `err_addr`.
  - If read and write are both out of range on the same edge, capture the read address.
  - Subsequent errors do not update `err_addr`. Only `rst` clears `err` and `err_addr`.

## Timing
- **Read latency:** a read sampled at edge k gives `mem_r_valid`=1 and its data in the cycle after edge k+RD_LATENCY-1.
  - RD_LATENCY=1: data appears right after edge k.
  - RD_LATENCY=2: data appears after edge k+1.
- **Strobe width:** `mem_r_valid` lasts exactly one cycle per accepted read. N consecutive read cycles produce N consecutive valid cycles, in order.
- **Write visibility:** a write at edge k is visible to a read sampled at edge k or later.
- **Error flag timing:** `err` and `err_addr` update at the same edge the offending request is sampled.
- **Reset mid-operation:**
  - Asserting `rst` clears outputs immediately (asynchronous); pending reads never strobe.
  - After deassertion, the first edge with `mem_r_en`=1 starts a fresh read.
  - An asserted `mem_w_en` is ignored while `rst`=1.

## Test plan
- **Basic write/read, RD_LATENCY=2:** write 0xBEEF to addr 0x0012 at edge 1; read 0x0012 at edge 3 -> `mem_r_valid`=1 with `mem_r_data`=0xBEEF after edge 4, and `mem_r_valid`=0 in the cycles before and after.
- **Back-to-back reads:** preload addrs 0..3 with 0x1000..0x1003, then read 0,1,2,3 on four consecutive edges -> four consecutive valid cycles returning 0x1000, 0x1001, 0x1002, 0x1003 in order.
- **Same-edge collision:** addr 0x0005 holds 0x1111; at one edge read 0x0005 and write 0x2222 to 0x0005 -> the read returns 0x2222. A further write of 0x3333 on the next edge does not change the in-flight result.
- **Out of range, ADDR_BITS=8:**
  - Step 1: read addr 0x0100 -> valid strobe with data 0, `err`=1, `err_addr`=0x0100.
  - Step 2: write 0xAAAA to 0x0200 -> dropped, `err_addr` stays 0x0100.
  - Step 3: read 0x0000 -> returns prior contents, unchanged by step 2.
- **Reset mid-read:** issue a read at edge k, assert `rst` before edge k+1 -> no `mem_r_valid` ever appears, and all outputs are 0 during reset. A post-reset read of a previously written address returns its stored value.
- **Latency sweep:** repeat the basic write/read with RD_LATENCY=1 and RD_LATENCY=4 -> the strobe appears 1 and 4 cycles after the request edge respectively, with identical data.

Source files
------------

// File: rtl/bb_mem_responder.sv
// bb_mem_responder
// Memory-side responder for the black_bean memory port. Services word reads
// and writes against an internal word-addressed array. Reads return data
// after RD_LATENCY cycles with a one-cycle valid strobe. Out-of-range
// accesses are flagged through a sticky error flag that holds the first
// offending address.
//
// Ports:
//   clk, rst      clock (rising edge) / asynchronous active-high reset
//   mem_r_en      read request, sampled every rising edge
//   mem_r_addr    read word address
//   mem_r_data    registered read data, holds last value between strobes
//   mem_r_valid   one-cycle strobe per accepted read
//   mem_w_en      write request, sampled every rising edge
//   mem_w_addr    write word address
//   mem_w_data    write data
//   err           sticky out-of-range flag
//   err_addr      address of the first out-of-range access since reset
module bb_mem_responder #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_BITS  = 8,
  parameter int RD_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_r_en,
  input  logic [DATA_WIDTH-1:0] mem_r_addr,
  output logic [DATA_WIDTH-1:0] mem_r_data,
  output logic                  mem_r_valid,
  input  logic                  mem_w_en,
  input  logic [DATA_WIDTH-1:0] mem_w_addr,
  input  logic [DATA_WIDTH-1:0] mem_w_data,
  output logic                  err,
  output logic [DATA_WIDTH-1:0] err_addr
);

  localparam int DEPTH = 1 << ADDR_BITS;

  generate
    if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_bad_latency
      $error("bb_mem_responder: RD_LATENCY must be in 1..4");
    end
  endgenerate

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  r_in_range;
  logic                  w_in_range;
  logic                  r_oor;
  logic                  w_oor;
  logic                  w_ok;
  logic [ADDR_BITS-1:0]  r_idx;
  logic [ADDR_BITS-1:0]  w_idx;
  logic [DATA_WIDTH-1:0] rd_word;

  // Pipeline stages: index 0 is loaded at the request edge, the last stage
  // drives the outputs.
  logic [RD_LATENCY-1:0] pv;
  logic [DATA_WIDTH-1:0] pd [RD_LATENCY];

  always_comb begin
    r_in_range = (mem_r_addr >> ADDR_BITS) == '0;
    w_in_range = (mem_w_addr >> ADDR_BITS) == '0;
    r_idx      = mem_r_addr[ADDR_BITS-1:0];
    w_idx      = mem_w_addr[ADDR_BITS-1:0];
    r_oor      = mem_r_en && !r_in_range;
    w_oor      = mem_w_en && !w_in_range;
    w_ok       = mem_w_en && w_in_range;
  end

  // Write-first: a same-edge write to the read address bypasses the array.
  always_comb begin
    rd_word = '0;
    if (r_in_range) begin
      if (w_ok && (w_idx == r_idx))
        rd_word = mem_w_data;
      else
        rd_word = mem[r_idx];
    end
  end

  // Array contents are deliberately not reset; reset only blocks writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
    end else if (w_ok) begin
      mem[w_idx] <= mem_w_data;
    end
  end

  // Data in each stage only advances alongside a valid token, so the last
  // stage keeps the most recently returned word while no strobe is present.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pv <= '0;
      for (int unsigned i = 0; i < RD_LATENCY; i++)
        pd[i] <= '0;
    end else begin
      pv[0] <= mem_r_en;
      if (mem_r_en)
        pd[0] <= rd_word;
      for (int unsigned i = 1; i < RD_LATENCY; i++) begin
        pv[i] <= pv[i-1];
        if (pv[i-1])
          pd[i] <= pd[i-1];
      end
    end
  end

  assign mem_r_valid = pv[RD_LATENCY-1];
  assign mem_r_data  = pd[RD_LATENCY-1];

  // Read address wins when both requests are out of range on one edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err      <= 1'b0;
      err_addr <= '0;
    end else if (!err) begin
      if (r_oor) begin
        err      <= 1'b1;
        err_addr <= mem_r_addr;
      end else if (w_oor) begin
        err      <= 1'b1;
        err_addr <= mem_w_addr;
      end
    end
  end

endmodule

// File: tb/tb_bb_mem_responder.sv
// Testbench for bb_mem_responder: three instances (RD_LATENCY 1, 2, 4) share
// one stimulus stream and are compared every cycle against a behavioural
// model that records each edge's read result and looks it up by edge number.
module tb_bb_mem_responder;

  localparam int DW = 16;
  localparam int NI = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          mem_r_en = 1'b0;
  logic [DW-1:0] mem_r_addr = '0;
  logic          mem_w_en = 1'b0;
  logic [DW-1:0] mem_w_addr = '0;
  logic [DW-1:0] mem_w_data = '0;

  logic          v_o  [NI];
  logic [DW-1:0] d_o  [NI];
  logic          e_o  [NI];
  logic [DW-1:0] ea_o [NI];

  always #5 clk = ~clk;

  generate
    for (genvar g = 0; g < NI; g++) begin : g_dut
      bb_mem_responder #(
        .DATA_WIDTH (16),
        .ADDR_BITS  (8),
        .RD_LATENCY (g == 0 ? 1 : (g == 1 ? 2 : 4))
      ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .mem_r_en    (mem_r_en),
        .mem_r_addr  (mem_r_addr),
        .mem_r_data  (d_o[g]),
        .mem_r_valid (v_o[g]),
        .mem_w_en    (mem_w_en),
        .mem_w_addr  (mem_w_addr),
        .mem_w_data  (mem_w_data),
        .err         (e_o[g]),
        .err_addr    (ea_o[g])
      );
    end
  endgenerate

  function automatic int lat_of(input int j);
    return (j == 0) ? 1 : ((j == 1) ? 2 : 4);
  endfunction

  // ---------------- behavioural model ----------------
  logic [DW-1:0] mm [256];
  int            ecount   = 0;
  int            rst_mark = 0;
  bit            rv   [0:8191];
  logic [DW-1:0] rdat [0:8191];
  logic          mv  [NI];
  logic [DW-1:0] md  [NI];
  logic          merr;
  logic [DW-1:0] mea;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rst_mark = ecount;
      merr = 1'b0;
      mea  = '0;
      for (int j = 0; j < NI; j++) begin
        mv[j] = 1'b0;
        md[j] = '0;
      end
    end else begin
      ecount++;
      rv[ecount] = mem_r_en;
      if (!mem_r_en || mem_r_addr >= 256)
        rdat[ecount] = '0;
      else if (mem_w_en && mem_w_addr == mem_r_addr)
        rdat[ecount] = mem_w_data;
      else
        rdat[ecount] = mm[mem_r_addr[7:0]];
      if (mem_w_en && mem_w_addr < 256)
        mm[mem_w_addr[7:0]] = mem_w_data;
      if (!merr) begin
        if (mem_r_en && mem_r_addr >= 256) begin
          merr = 1'b1; mea = mem_r_addr;
        end else if (mem_w_en && mem_w_addr >= 256) begin
          merr = 1'b1; mea = mem_w_addr;
        end
      end
      for (int j = 0; j < NI; j++) begin
        int src;
        src = ecount - lat_of(j) + 1;
        if (src > rst_mark && rv[src]) begin
          mv[j] = 1'b1;
          md[j] = rdat[src];
        end else begin
          mv[j] = 1'b0;
        end
      end
    end
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string nm, input int j, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (RD_LATENCY=%0d) at %0t: got %h, expected %h",
               nm, lat_of(j), $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int j = 0; j < NI; j++) begin
      chk("model_valid",    j, {15'b0, v_o[j]}, {15'b0, mv[j]});
      chk("model_data",     j, d_o[j], md[j]);
      chk("model_err",      j, {15'b0, e_o[j]}, {15'b0, merr});
      chk("model_err_addr", j, ea_o[j], mea);
    end
  end

  task automatic idle();
    mem_r_en = 1'b0;
    mem_w_en = 1'b0;
  endtask

  function automatic logic [DW-1:0] rand_addr();
    if ($urandom_range(0, 11) == 0)
      return DW'($urandom_range(256, 65535));
    return DW'($urandom_range(0, 255));
  endfunction

  // ---------------- stimulus + literal expectations ----------------
  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // preload every word so no read ever returns undefined contents
    for (int a = 0; a < 256; a++) begin
      mem_w_en = 1'b1; mem_w_addr = DW'(a); mem_w_data = DW'($urandom);
      @(negedge clk);
    end
    idle();

    // basic write/read and latency sweep
    @(negedge clk);
    mem_w_en = 1'b1; mem_w_addr = 16'h0012; mem_w_data = 16'hBEEF;
    @(negedge clk); idle();
    @(negedge clk); mem_r_en = 1'b1; mem_r_addr = 16'h0012;
    @(negedge clk); idle();
    chk("lit_basic_v_k",  0, {15'b0, v_o[0]}, 16'd1);
    chk("lit_basic_d_k",  0, d_o[0], 16'hBEEF);
    chk("lit_basic_v_k",  1, {15'b0, v_o[1]}, 16'd0);
    chk("lit_basic_v_k",  2, {15'b0, v_o[2]}, 16'd0);
    @(negedge clk);
    chk("lit_basic_v_k1", 1, {15'b0, v_o[1]}, 16'd1);
    chk("lit_basic_d_k1", 1, d_o[1], 16'hBEEF);
    chk("lit_basic_v_k1", 0, {15'b0, v_o[0]}, 16'd0);
    chk("lit_hold_d",     0, d_o[0], 16'hBEEF);
    @(negedge clk);
    chk("lit_basic_v_k2", 1, {15'b0, v_o[1]}, 16'd0);
    @(negedge clk);
    chk("lit_basic_v_k3", 2, {15'b0, v_o[2]}, 16'd1);
    chk("lit_basic_d_k3", 2, d_o[2], 16'hBEEF);
    @(negedge clk);
    chk("lit_basic_v_k4", 2, {15'b0, v_o[2]}, 16'd0);

    // back-to-back reads
    for (int a = 0; a < 4; a++) begin
      mem_w_en = 1'b1; mem_w_addr = DW'(a); mem_w_data = 16'h1000 + DW'(a);
      @(negedge clk);
    end
    idle();
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      if (c >= 2 && c <= 5) begin
        chk("lit_b2b_v", 1, {15'b0, v_o[1]}, 16'd1);
        chk("lit_b2b_d", 1, d_o[1], 16'h1000 + DW'(c - 2));
      end else if (c == 1 || c == 6) begin
        chk("lit_b2b_v_off", 1, {15'b0, v_o[1]}, 16'd0);
      end
      if (c < 4) begin
        mem_r_en = 1'b1; mem_r_addr = DW'(c);
      end else begin
        idle();
      end
    end

    // same-edge collision
    @(negedge clk);
    mem_w_en = 1'b1; mem_w_addr = 16'h0005; mem_w_data = 16'h1111;
    @(negedge clk);
    mem_r_en = 1'b1; mem_r_addr = 16'h0005; mem_w_data = 16'h2222;
    @(negedge clk);
    chk("lit_coll_d", 0, d_o[0], 16'h2222);
    mem_r_en = 1'b0; mem_w_data = 16'h3333;
    @(negedge clk); idle();
    chk("lit_coll_d", 1, d_o[1], 16'h2222);
    chk("lit_coll_v", 1, {15'b0, v_o[1]}, 16'd1);
    @(negedge clk);
    @(negedge clk);
    chk("lit_coll_d", 2, d_o[2], 16'h2222);

    // out of range
    @(negedge clk);
    mem_r_en = 1'b1; mem_r_addr = 16'h0100;
    @(negedge clk);
    chk("lit_oor_v",    0, {15'b0, v_o[0]}, 16'd1);
    chk("lit_oor_d",    0, d_o[0], 16'h0000);
    chk("lit_oor_err",  1, {15'b0, e_o[1]}, 16'd1);
    chk("lit_oor_addr", 1, ea_o[1], 16'h0100);
    mem_r_en = 1'b0;
    mem_w_en = 1'b1; mem_w_addr = 16'h0200; mem_w_data = 16'hAAAA;
    @(negedge clk);
    chk("lit_oor_addr_sticky", 2, ea_o[2], 16'h0100);
    mem_w_en = 1'b0; mem_r_en = 1'b1; mem_r_addr = 16'h0000;
    @(negedge clk); idle();
    chk("lit_oor_prior", 0, d_o[0], 16'h1000);
    repeat (4) @(negedge clk);

    // reset mid-read
    mem_r_en = 1'b1; mem_r_addr = 16'h0012;
    @(posedge clk);
    #2 rst = 1'b1;
    mem_r_en = 1'b0;
    mem_w_en = 1'b1; mem_w_addr = 16'h0012; mem_w_data = 16'hDEAD;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      for (int j = 0; j < NI; j++) begin
        chk("lit_rst_v",    j, {15'b0, v_o[j]}, 16'd0);
        chk("lit_rst_d",    j, d_o[j], 16'h0000);
        chk("lit_rst_err",  j, {15'b0, e_o[j]}, 16'd0);
        chk("lit_rst_addr", j, ea_o[j], 16'h0000);
      end
    end
    rst = 1'b0;
    mem_w_en = 1'b0; mem_r_en = 1'b1; mem_r_addr = 16'h0012;
    @(negedge clk); idle();
    chk("lit_post_rst_v", 1, {15'b0, v_o[1]}, 16'd0);
    @(negedge clk);
    chk("lit_post_rst_v", 1, {15'b0, v_o[1]}, 16'd1);
    chk("lit_post_rst_d", 1, d_o[1], 16'hBEEF);

    // randomized traffic with one asynchronous reset pulse
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      mem_r_en   = ($urandom_range(0, 9) < 6);
      mem_r_addr = rand_addr();
      mem_w_en   = ($urandom_range(0, 9) < 4);
      mem_w_addr = ($urandom_range(0, 3) == 0) ? mem_r_addr : rand_addr();
      mem_w_data = DW'($urandom);
      if (i == 700) begin
        #3 rst = 1'b1;
        #10 rst = 1'b0;
      end
    end
    @(negedge clk); idle();
    repeat (6) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
